alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit ALU (AND/OR/ADD/SUB/SHL/SHR/ASR) between NREQ requesters. Each requester issues an operation over a valid/ready request channel and receives the registered result on its own valid/ready response channel. The block sits between the requesting engines and the single ALU datapath, which it instantiates internally.

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu_core.sv | 27 ++
 rtl/alu_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the ALU arbiter: data/opcode widths,
// opcode encodings and the sequencer state type.
package alu_arb_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b101;
  localparam logic [OP_W-1:0] OP_ASR  = 3'b110;
  localparam logic [OP_W-1:0] OP_NONE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 16-bit ALU shared by all requesters.
module alu_core
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] y_o
);

  // Opcode decode; add/sub wrap, shifts move by one bit
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_SHL:  y_o = {a_i[DATA_W-2:0], 1'b0};
      OP_SHR:  y_o = {1'b0, a_i[DATA_W-1:1]};
      OP_ASR:  y_o = {a_i[DATA_W-1], a_i[DATA_W-1:1]};
      OP_NONE: y_o = '0;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between NREQ requesters.
// Optional feature: define ALU_ARB_STATS_EN to add per-requester saturating
// grant counters on the stat_grants port.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  input  logic [OP_W*NREQ-1:0]   req_op,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [DATA_W*NREQ-1:0] stat_grants
`endif
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CW    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] a_arr  [NREQ];
  logic [DATA_W-1:0] b_arr  [NREQ];
  logic [OP_W-1:0]   op_arr [NREQ];

  logic              found_c;
  logic [IDX_W-1:0]  winner_c;
  logic [CW-1:0]     cand_c;
  logic [DATA_W-1:0] alu_out_c;

  // Unpack the flat requester buses
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
    assign b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
    assign op_arr[gi] = req_op[OP_W*gi +: OP_W];
  end

  // Round-robin search starting at ptr, wrapping modulo NREQ
  always_comb begin
    found_c  = 1'b0;
    winner_c = '0;
    cand_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_c = {1'b0, ptr_q} + CW'(k);
      if (cand_c >= CW'(NREQ)) cand_c = cand_c - CW'(NREQ);
      if (!found_c && req_valid[cand_c[IDX_W-1:0]]) begin
        found_c  = 1'b1;
        winner_c = cand_c[IDX_W-1:0];
      end
    end
  end

  // Grant is combinational, only while idle
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found_c) req_ready[winner_c] = 1'b1;
  end

  alu_core u_alu (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (alu_out_c)
  );

  // Sequencer next-state: capture, execute, hold response until consumed
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          a_d     = a_arr[winner_c];
          b_d     = b_arr[winner_c];
          op_d    = op_arr[winner_c];
          owner_d = winner_c;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_out_c;
        for (int unsigned i = 0; i < NREQ; i++) begin
          rsp_valid_d[i] = (IDX_W'(i) == owner_q);
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          ptr_d       = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

`ifdef ALU_ARB_STATS_EN
  logic [DATA_W-1:0] grant_cnt_q [NREQ];
  logic [DATA_W-1:0] grant_cnt_d [NREQ];

  // Saturating per-requester acceptance counters
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (req_ready[i] && grant_cnt_q[i] != '1) begin
        grant_cnt_d[i] = grant_cnt_q[i] + DATA_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end

  for (genvar gs = 0; gs < NREQ; gs++) begin : g_stats
    assign stat_grants[DATA_W*gs +: DATA_W] = grant_cnt_q[gs];
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table of single operations,
// plus contention, backpressure and reset-in-response sequences.
module tb_alu_arbiter;

  localparam int NREQ = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [16*NREQ-1:0]   req_a;
  logic [16*NREQ-1:0]   req_b;
  logic [3*NREQ-1:0]    req_op;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [15:0]          rsp_data;
  logic                 busy;
`ifdef ALU_ARB_STATS_EN
  logic [16*NREQ-1:0]   stat_grants;
`endif

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          req;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   total;
  int   bad;
  bit   in_drive;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int r);
    logic [NREQ-1:0] one;
    one = NREQ'(1);
    return one << r;
  endfunction

  // Sample point: falling edge; scoreboard pops on each completed response handshake
  task automatic to_sample();
    exp_t e;
    @(negedge clk);
    in_drive = 1'b0;
    if (rst_n && (rsp_valid & rsp_ready) != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_owner", 32'(rsp_valid), 32'(oh(e.req)));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  endtask

  // Drive point: just after the rising edge; never skips a sample point
  task automatic to_drive();
    if (in_drive) to_sample();
    @(posedge clk);
    #1;
    in_drive = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
    req_a[16*r +: 16] = a;
    req_b[16*r +: 16] = b;
    req_op[3*r +: 3]  = op;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 30 && sb.size() != 0; c++) begin
      to_sample();
      to_drive();
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic apply_reset();
    to_drive();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    sb.delete();
    to_sample();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    to_drive();
    rst_n = 1'b1;
  endtask

  // One isolated operation with rsp_ready high: grant, exec, response, idle
  task automatic do_op(input int r, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic [15:0] exp);
    exp_t e;
    to_drive();
    set_req(r, a, b, op);
    req_valid = oh(r);
    to_sample();
    check("grant", 32'(req_ready), 32'(oh(r)));
    e.req = r; e.data = exp;
    sb.push_back(e);
    to_drive();
    req_valid = '0;
    set_req(r, ~a, ~b, ~op);
    to_sample();
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    to_drive();
    to_sample();
    check("lat_rsp_valid", 32'(rsp_valid), 32'(oh(r)));
    check("lat_rsp_data", 32'(rsp_data), 32'(exp));
    to_drive();
    to_sample();
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    total     = 0;
    bad       = 0;
    in_drive  = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '1;

    vecs[0] = '{0, 16'h00F0, 16'h0F0F, 3'b001, 16'h0FFF};
    vecs[1] = '{1, 16'hF0F0, 16'h3C3C, 3'b000, 16'h3030};
    vecs[2] = '{0, 16'h1234, 16'h1111, 3'b010, 16'h2345};
    vecs[3] = '{1, 16'h0005, 16'h0007, 3'b011, 16'hFFFE};
    vecs[4] = '{0, 16'h8001, 16'h0000, 3'b100, 16'h0002};
    vecs[5] = '{1, 16'h8001, 16'h0000, 3'b101, 16'h4000};
    vecs[6] = '{0, 16'h8001, 16'h0000, 3'b110, 16'hC000};
    vecs[7] = '{0, 16'h8001, 16'hFFFF, 3'b111, 16'h0000};
    vecs[8] = '{1, 16'h7FFE, 16'h0000, 3'b110, 16'h3FFF};
    vecs[9] = '{0, 16'hFFFF, 16'h0001, 3'b010, 16'h0000};

    apply_reset();
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    end
    drain("vec_drain");

    // Contention from reset: grants alternate 0,1,0,1
    apply_reset();
    set_req(0, 16'hFFFF, 16'h0001, 3'b010);
    set_req(1, 16'h0000, 16'h0001, 3'b011);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      to_sample();
      check("rr_grant", 32'(req_ready), 32'(oh(g % 2)));
      e.req  = g % 2;
      e.data = (g % 2 == 0) ? 16'h0000 : 16'hFFFF;
      sb.push_back(e);
      to_drive();
      to_sample();
      to_drive();
      to_sample();
      to_drive();
    end
    req_valid = '0;
    drain("rr_drain");

    // Backpressure on requester 0 while requester 1 waits
    to_drive();
    rsp_ready = 2'b10;
    set_req(0, 16'hFFFF, 16'h00FF, 3'b000);
    req_valid = 2'b01;
    to_sample();
    check("bp_grant", 32'(req_ready), 32'd1);
    e.req = 0; e.data = 16'h00FF;
    sb.push_back(e);
    to_drive();
    set_req(1, 16'h0001, 16'h0002, 3'b001);
    req_valid = 2'b10;
    to_sample();
    check("bp_exec_ready", 32'(req_ready), 32'd0);
    to_drive();
    to_sample();
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int h = 0; h < 5; h++) begin
      to_drive();
      to_sample();
      check("bp_hold_data", 32'(rsp_data), 32'h00FF);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_busy", 32'(busy), 32'd1);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    to_drive();
    rsp_ready = 2'b11;
    to_sample();
    to_drive();
    to_sample();
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'd2);
    e.req = 1; e.data = 16'h0003;
    sb.push_back(e);
    to_drive();
    req_valid = '0;
    drain("bp_drain");

    // Reset while requester 1 holds a response; ptr returns to 0
    do_op(0, 16'h1234, 16'h5678, 3'b111, 16'h0000);
    to_drive();
    rsp_ready = 2'b00;
    set_req(1, 16'h0009, 16'h0002, 3'b011);
    req_valid = 2'b10;
    to_sample();
    check("rr_ptr1_grant", 32'(req_ready), 32'd2);
    e.req = 1; e.data = 16'h0007;
    sb.push_back(e);
    to_drive();
    req_valid = '0;
    to_sample();
    to_drive();
    to_sample();
    check("pre_rst_valid", 32'(rsp_valid), 32'd2);
    check("pre_rst_data", 32'(rsp_data), 32'h0007);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_data", 32'(rsp_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    to_drive();
    to_sample();
    to_drive();
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    set_req(0, 16'h00FF, 16'h0F0F, 3'b000);
    set_req(1, 16'h1000, 16'h0001, 3'b001);
    req_valid = 2'b11;
    to_sample();
    check("post_rst_grant", 32'(req_ready), 32'd1);
    e.req = 0; e.data = 16'h000F;
    sb.push_back(e);
    to_drive();
    to_sample();
    to_drive();
    to_sample();
    to_drive();
    to_sample();
    check("post_rst_grant2", 32'(req_ready), 32'd2);
    e.req = 1; e.data = 16'h1001;
    sb.push_back(e);
    to_drive();
    req_valid = '0;
    drain("rst_drain");

`ifdef ALU_ARB_STATS_EN
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      do_op(1, 16'h0001, 16'h0001, 3'b010, 16'h0002);
    end
    check("stat_grants", 32'(stat_grants), {16'd3, 16'd0});
    drain("stat_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
